serial_frame_rx: RTL

//  Receive end of the single-bit serial line (D) driven by the D_FF-based shift/stimulus logic.

---
 rtl/serial_frame_rx_pkg.sv | 21 ++
 rtl/serial_frame_rx_if.sv | 37 +++
 rtl/serial_frame_rx_sync_2ff.sv | 31 +++
 rtl/serial_frame_rx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_frame_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_frame_rx_pkg
// Shared definitions for the serial frame link: receiver FSM state encoding
// and the default frame geometry (also used by the transmit side).
// -----------------------------------------------------------------------------
package serial_frame_rx_pkg;

    // Default bit timing and word size shared by transmitter and receiver.
    localparam int CLKS_PER_BIT_DEF = 4;
    localparam int DATA_BITS_DEF    = 8;

    // Receiver FSM states; encodings are fixed so they match the transmitter docs.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/serial_frame_rx_if.sv
// -----------------------------------------------------------------------------
// serial_frame_rx_if
// Bundles the serial line and the received-word outputs of serial_frame_rx.
//   D          : serial line (idle high), driven by the line side
//   data_out   : last good word
//   data_valid : one-cycle strobe when data_out updates
//   frame_err  : one-cycle strobe when a stop bit samples low
//   busy       : receiver is not idle
// Modports: master = line driver / word consumer, slave = receiver.
// -----------------------------------------------------------------------------
interface serial_frame_rx_if
    import serial_frame_rx_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic                 D;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output D,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  D,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/serial_frame_rx_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for the asynchronous serial line. Both flops reset
// to 1 so a reset never looks like a start edge.
//   clk   : system clock
//   reset : asynchronous, active-high
//   d     : asynchronous input
//   q     : synchronised output (2-cycle latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
// Receives framed words on a single idle-high serial line: one start bit (0),
// DATA_BITS data bits LSB first, one stop bit (1). Each bit lasts
// CLKS_PER_BIT clocks and is sampled once. A good stop bit updates data_out
// with a one-cycle data_valid; a low stop bit gives a one-cycle frame_err and
// the receiver then waits for the line to go high again before re-arming.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   rx    : slave side of serial_frame_rx_if (D in; data_out, data_valid,
//           frame_err, busy out -- all outputs registered)
// -----------------------------------------------------------------------------
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    serial_frame_rx_if.slave rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Start bit is checked half-way through; data and stop bits at the last
    // clock of their bit period, which lands mid-bit on the synchronised line.
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

    logic                 ds_s;
    rx_state_e            state_q,      state_d;
    logic [CW-1:0]        clk_cnt_q,    clk_cnt_d;
    logic [BW-1:0]        bit_idx_q,    bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q,      shreg_d;
    logic [DATA_BITS-1:0] data_out_q,   data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 busy_q,       busy_d;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx.D),
        .q     (ds_s)
    );

    // Next-state, counter, shift register and output strobe logic.
    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = {CW{1'b0}};
                bit_idx_d = {BW{1'b0}};
                if (!ds_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (clk_cnt_q == CNT_MID) begin
                    clk_cnt_d = {CW{1'b0}};
                    bit_idx_d = {BW{1'b0}};
                    // A line that is high again at mid start bit was a glitch.
                    if (!ds_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            ST_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d          = {CW{1'b0}};
                    shreg_d[bit_idx_q] = ds_s;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = {BW{1'b0}};
                        state_d   = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            ST_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = {CW{1'b0}};
                    if (ds_s) begin
                        data_out_d   = shreg_q;
                        data_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        frame_err_d  = 1'b1;
                        state_d      = ST_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            ST_BREAK: begin
                // Stay here while the line is held low so it cannot retrigger.
                clk_cnt_d = {CW{1'b0}};
                bit_idx_d = {BW{1'b0}};
                if (ds_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end

            default: begin
                clk_cnt_d = {CW{1'b0}};
                bit_idx_d = {BW{1'b0}};
                state_d   = ST_IDLE;
            end
        endcase

        // Registered busy tracks the registered state exactly.
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clk_cnt_q    <= {CW{1'b0}};
            bit_idx_q    <= {BW{1'b0}};
            shreg_q      <= {DATA_BITS{1'b0}};
            data_out_q   <= {DATA_BITS{1'b0}};
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign rx.data_out   = data_out_q;
    assign rx.data_valid = data_valid_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.busy       = busy_q;
endmodule
